// File: rtl/intf_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : intf_rr_arbiter_if
//  Description : Bundle of request, grant and shared-slot signals between N
//                requesters and the round-robin arbiter that owns the slot.
//  Revision    : 1.0 - initial release
// ============================================================================
interface intf_rr_arbiter_if #(
    parameter int N    = 2,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]    req;
    logic [N-1:0]    value;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic            bus_value;
    logic            preempt;

    // Requester side: raises requests and data, observes grant
    modport master (
        output req, value,
        input  gnt, gnt_valid, gnt_idx, bus_value, preempt
    );

    // Arbiter side: samples requests, drives grant and the shared slot
    modport slave (
        input  req, value,
        output gnt, gnt_valid, gnt_idx, bus_value, preempt
    );
endinterface
`default_nettype wire

// File: rtl/intf_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : intf_rr_arbiter
//  Description : Round-robin arbiter sharing one single-bit slot among N
//                requesters, with a bounded hold time that hands the slot to
//                a waiting requester once the owner has held it MAX_HOLD
//                consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module intf_rr_arbiter #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 8,
    parameter int IDXW     = (N > 1) ? $clog2(N) : 1,
    parameter int HOLDW    = $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    intf_rr_arbiter_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [IDXW:0]    c_N_EXT    = (IDXW + 1)'(N);
    localparam logic [IDXW-1:0]  c_LAST_IDX = IDXW'(N - 1);
    localparam logic [HOLDW-1:0] c_MAX_HOLD = HOLDW'(MAX_HOLD);

    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic             r_gnt_valid;
    logic [IDXW-1:0]  r_gnt_idx;
    logic             r_preempt;
    logic [HOLDW-1:0] r_hold_cnt;
    logic [IDXW-1:0]  r_ptr;

    logic [N-1:0]     w_cand;
    logic [2*N-1:0]   w_shift;
    logic [IDXW-1:0]  w_off;
    logic [IDXW:0]    w_sum;
    logic             w_found;
    logic [IDXW-1:0]  w_win;
    logic [IDXW-1:0]  w_ptr_next;
    logic             w_owner_req;

    // Current owner is excluded from the search so a handover always picks
    // someone else; the doubled vector rotated by ptr turns the circular
    // scan into a plain lowest-set-bit search.
    always_comb begin
        w_cand  = bus.req & ~r_gnt;
        w_shift = {w_cand, w_cand} >> r_ptr;
        w_found = 1'b0;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_shift[i]) begin
                w_found = 1'b1;
                w_off   = IDXW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_N_EXT) begin
            w_sum = w_sum - c_N_EXT;
        end
        w_win      = w_sum[IDXW-1:0];
        w_ptr_next = (w_win == c_LAST_IDX) ? '0 : w_win + IDXW'(1);
    end

    // Owner still wants the slot (only meaningful while busy)
    assign w_owner_req = |(bus.req & r_gnt);

    // Arbitration state machine with registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
            r_preempt   <= 1'b0;
            r_hold_cnt  <= '0;
            r_ptr       <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state     <= ST_BUSY;
                        r_gnt       <= N'(1) << w_win;
                        r_gnt_valid <= 1'b1;
                        r_gnt_idx   <= w_win;
                        r_hold_cnt  <= HOLDW'(1);
                        r_ptr       <= w_ptr_next;
                    end
                end
                ST_BUSY: begin
                    if (!w_owner_req) begin
                        // Release: hand over without a bubble, or go idle
                        if (w_found) begin
                            r_gnt      <= N'(1) << w_win;
                            r_gnt_idx  <= w_win;
                            r_hold_cnt <= HOLDW'(1);
                            r_ptr      <= w_ptr_next;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_gnt       <= '0;
                            r_gnt_valid <= 1'b0;
                            r_gnt_idx   <= '0;
                            r_hold_cnt  <= '0;
                        end
                    end else if (r_hold_cnt < c_MAX_HOLD) begin
                        r_hold_cnt <= r_hold_cnt + HOLDW'(1);
                    end else if (w_found) begin
                        // Hold time exhausted and someone else is waiting
                        r_gnt      <= N'(1) << w_win;
                        r_gnt_idx  <= w_win;
                        r_hold_cnt <= HOLDW'(1);
                        r_ptr      <= w_ptr_next;
                        r_preempt  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_gnt_valid <= 1'b0;
                    r_gnt_idx   <= '0;
                    r_hold_cnt  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.preempt   = r_preempt;
    // Shared slot follows the owner's live data bit
    assign bus.bus_value = r_gnt_valid ? bus.value[r_gnt_idx] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_intf_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intf_rr_arbiter
//  Description : Directed self-checking bench for intf_rr_arbiter with
//                N=4, MAX_HOLD=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intf_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 3;
    localparam int IDXW     = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    intf_rr_arbiter_if #(.N(N), .IDXW(IDXW)) bus ();

    intf_rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.value = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.preempt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: gnt=%b valid=%b idx=%0d preempt=%b, required all zero",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.preempt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.bus_value} !== 8'h00) begin
                errors++;
                $display("FAIL idle_cycle%0d: gnt=%b valid=%b idx=%0d bus=%b, required all zero",
                         i, bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.bus_value);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 4'b1010;
        cyc();
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_idx} !== {4'b0010, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL b2b_first: gnt=%b valid=%b idx=%0d, required 0010 1 1",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
        bus.req = 4'b1000;
        cyc();
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.preempt} !== {4'b1000, 1'b1, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: gnt=%b valid=%b idx=%0d preempt=%b, required 1000 1 3 0",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.preempt);
        end
        bus.req = 4'b0000;
        cyc();
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_idx} !== 7'b0) begin
            errors++;
            $display("FAIL b2b_idle: gnt=%b valid=%b idx=%0d, required 0000 0 0",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.preempt} !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL sat_cycle%0d: gnt=%b valid=%b idx=%0d preempt=%b, required 0001 1 0 0",
                         i, bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.preempt);
            end
        end
        bus.req = 4'b0000;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL sat_release: gnt=%b, required 0000", bus.gnt);
        end
    endtask

    task automatic test_preempt();
        logic [3:0] exp_gnt [6];
        logic       exp_pre [6];
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001};
        exp_pre = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        bus.req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if ({bus.gnt, bus.preempt} !== {exp_gnt[i], exp_pre[i]}) begin
                errors++;
                $display("FAIL preempt_cycle%0d: gnt=%b preempt=%b, required %b %b",
                         i, bus.gnt, bus.preempt, exp_gnt[i], exp_pre[i]);
            end
            if (i == 1) bus.req = 4'b0101;
            if (i == 4) bus.req = 4'b0001;
        end
        bus.req = 4'b0000;
        cyc();
    endtask

    task automatic test_bus_value();
        logic [3:0] vals [5];
        logic       exp  [5];
        vals = '{4'b0100, 4'b0000, 4'b0001, 4'b0101, 4'b0100};
        exp  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        bus.req   = 4'b0100;
        bus.value = 4'b0100;
        cyc();
        checks++;
        if (bus.gnt_idx !== 2'd2) begin
            errors++;
            $display("FAIL value_owner: idx=%0d, required 2", bus.gnt_idx);
        end
        for (int i = 0; i < 5; i++) begin
            bus.value = vals[i];
            #1;
            checks++;
            if (bus.bus_value !== exp[i]) begin
                errors++;
                $display("FAIL value_step%0d: bus_value=%b, required %b (value=%b)",
                         i, bus.bus_value, exp[i], vals[i]);
            end
        end
        bus.req = 4'b0000;
        cyc();
        checks++;
        if (bus.bus_value !== 1'b0) begin
            errors++;
            $display("FAIL value_idle: bus_value=%b, required 0", bus.bus_value);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b1010;
        cyc();
        bus.req = 4'b1000;
        cyc();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL arst_setup: gnt=%b, required 1000", bus.gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_idx} !== 7'b0) begin
            errors++;
            $display("FAIL arst_drop: gnt=%b valid=%b idx=%0d, required 0000 0 0",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
        bus.req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({bus.gnt, bus.gnt_idx} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL arst_regrant: gnt=%b idx=%0d, required 0001 0", bus.gnt, bus.gnt_idx);
        end
        // Owner 1 leaves ptr at 2; only a reset pointer picks 0 from 1001
        bus.req = 4'b0000;
        cyc();
        bus.req = 4'b0010;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.gnt_valid} !== 5'b0) begin
            errors++;
            $display("FAIL arst_drop2: gnt=%b valid=%b, required 0000 0", bus.gnt, bus.gnt_valid);
        end
        bus.req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({bus.gnt, bus.gnt_idx} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL arst_ptr: gnt=%b idx=%0d, required 0001 0", bus.gnt, bus.gnt_idx);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.value = '0;
        test_reset();
        test_back_to_back();
        test_saturate();
        test_preempt();
        test_bus_value();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
